// File: rtl/adder_byte_sequencer_pkg.sv
// Shared definitions for the byte-serial add/subtract sequencer.
package adder_byte_sequencer_pkg;

    localparam int BYTE = 8;

    // Encoding 2'd3 is never entered; the FSM decodes it as idle.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/adder_byte_sequencer_byte_add_slice.sv
// One 8-bit adder slice: sum, carry into bit 7 (for the overflow term), carry out.
module byte_add_slice
    import adder_byte_sequencer_pkg::*;
(
    input  logic [BYTE-1:0] a,
    input  logic [BYTE-1:0] b,
    input  logic            cin,
    output logic [BYTE-1:0] sum,
    output logic            c7,
    output logic            cout
);

    logic [BYTE-1:0] gen;
    logic [BYTE-1:0] prop;
    logic [BYTE:0]   carry;

    assign gen  = a & b;
    assign prop = a ^ b;

    // Carry chain from generate/propagate terms, bit 0 upward.
    always_comb begin
        carry    = '0;
        carry[0] = cin;
        for (int i = 0; i < BYTE; i++) begin
            carry[i+1] = gen[i] | (prop[i] & carry[i]);
        end
    end

    assign sum  = prop ^ carry[BYTE-1:0];
    assign c7   = carry[BYTE-1];
    assign cout = carry[BYTE];

endmodule

// File: rtl/adder_byte_sequencer.sv
// Byte-serial (8*NBYTES)-bit add/subtract controller around one 8-bit slice.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | waiting for a request; in_ready high; last result retained
//   ST_RUN  | one byte per cycle through the slice, LSB first
//   ST_DONE | result valid, held until out_ready
module adder_byte_sequencer
    import adder_byte_sequencer_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [BYTE*NBYTES-1:0] in_a,
    input  logic [BYTE*NBYTES-1:0] in_b,
    input  logic                   in_sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [BYTE*NBYTES-1:0] out_result,
    output logic                   out_carry,
    output logic                   out_overflow,
    output logic                   busy
);

    localparam int W     = BYTE * NBYTES;
    localparam int IDX_W = $clog2(NBYTES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

    seq_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     result_q, result_d;
    logic             ocarry_q, ocarry_d;
    logic             ovf_q, ovf_d;

    logic [BYTE-1:0]  a_byte;
    logic [BYTE-1:0]  b_byte;
    logic [BYTE-1:0]  slice_sum;
    logic             slice_c7;
    logic             slice_cout;

    assign a_byte = a_q[idx_q*BYTE +: BYTE];
    assign b_byte = b_q[idx_q*BYTE +: BYTE];

    byte_add_slice u_slice (
        .a    (a_byte),
        .b    (b_byte),
        .cin  (carry_q),
        .sum  (slice_sum),
        .c7   (slice_c7),
        .cout (slice_cout)
    );

    // Next-state, operand capture, byte demux into the result register.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        result_d = result_q;
        ocarry_d = ocarry_q;
        ovf_d    = ovf_q;
        case (state_q)
            ST_RUN: begin
                result_d[idx_q*BYTE +: BYTE] = slice_sum;
                carry_d = slice_cout;
                if (idx_q == IDX_LAST) begin
                    ocarry_d = slice_cout;
                    ovf_d    = slice_c7 ^ slice_cout;
                    state_d  = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                // Idle, and the unused encoding behaves as idle.
                state_d = ST_IDLE;
                if (in_valid) begin
                    state_d = ST_RUN;
                    a_d     = in_a;
                    b_d     = in_b ^ {W{in_sub}};
                    carry_d = in_sub;
                    idx_d   = '0;
                end
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            ocarry_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            ocarry_q <= ocarry_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy         = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign in_ready     = !busy;
    assign out_valid    = (state_q == ST_DONE);
    assign out_result   = result_q;
    assign out_carry    = ocarry_q;
    assign out_overflow = ovf_q;

endmodule

// File: tb/tb_adder_byte_sequencer.sv
// Bench for adder_byte_sequencer (NBYTES=4) against an arithmetic reference model.
module tb_adder_byte_sequencer;

    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;

    logic         clock;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_carry;
    logic         out_overflow;
    logic         busy;

    int checks = 0;
    int errors = 0;

    adder_byte_sequencer #(.NBYTES(NBYTES)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_sub       (in_sub),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_carry    (out_carry),
        .out_overflow (out_overflow),
        .busy         (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: full-width arithmetic; overflow from operand/result signs.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sub);
        logic [W:0]   full;
        logic [W-1:0] r;
        logic         ovf;
        if (sub) begin
            full = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
            r    = full[W-1:0];
            ovf  = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        end else begin
            full = {1'b0, a} + {1'b0, b};
            r    = full[W-1:0];
            ovf  = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
        end
        return {ovf, full[W], r};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One transaction: accept, latency, result, hold stability, release.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                          input int hold, input string name);
        logic [W+1:0] exp;
        int           lat;
        exp = model(a, b, sub);
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        in_valid = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s in_ready before accept: got %b want 1", name, in_ready);
        end
        step();
        in_valid = 1'b0;
        in_a     = W'($urandom);
        in_b     = W'($urandom);
        in_sub   = 1'($urandom);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            checks++;
            if (busy !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s run flags: busy %b in_ready %b want 1 0", name, busy, in_ready);
            end
            step();
            lat++;
        end
        checks++;
        if (lat != NBYTES) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, NBYTES);
        end
        checks++;
        if ({out_overflow, out_carry, out_result} !== exp) begin
            errors++;
            $display("FAIL %s result: got r=%h c=%b v=%b want r=%h c=%b v=%b", name,
                     out_result, out_carry, out_overflow, exp[W-1:0], exp[W], exp[W+1]);
        end
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            step();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 ||
                {out_overflow, out_carry, out_result} !== exp) begin
                errors++;
                $display("FAIL %s hold %0d: valid %b in_ready %b r=%h c=%b v=%b want r=%h",
                         name, i, out_valid, in_ready, out_result, out_carry, out_overflow,
                         exp[W-1:0]);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 ||
            {out_overflow, out_carry, out_result} !== exp) begin
            errors++;
            $display("FAIL %s after release: valid %b in_ready %b busy %b r=%h want 0 1 0 r=%h",
                     name, out_valid, in_ready, busy, out_result, exp[W-1:0]);
        end
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_sub    = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
            out_result !== '0 || out_carry !== 1'b0 || out_overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset: in_ready %b out_valid %b busy %b r=%h c=%b v=%b want 1 0 0 0 0 0",
                     in_ready, out_valid, busy, out_result, out_carry, out_overflow);
        end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_directed();
        run_op(32'h000000FF, 32'h00000001, 1'b0, 0, "add_byte_carry");
        run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 0, "add_signed_ovf");
        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 0, "add_wrap");
        run_op(32'h00000005, 32'h00000007, 1'b1, 0, "sub_borrow");
    endtask

    task automatic test_hold();
        run_op(32'h80000000, 32'h00000001, 1'b1, 5, "sub_ovf_hold");
    endtask

    task automatic test_idle_out_ready();
        // out_ready pulsed while idle must not disturb anything.
        out_ready = 1'b1;
        step();
        step();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== 32'h7FFFFFFF) begin
            errors++;
            $display("FAIL idle_out_ready: valid %b in_ready %b r=%h want 0 1 7fffffff",
                     out_valid, in_ready, out_result);
        end
    endtask

    task automatic test_mid_reset();
        in_a     = 32'h12345678;
        in_b     = 32'h11111111;
        in_sub   = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 ||
            out_result !== '0 || out_carry !== 1'b0 || out_overflow !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: valid %b in_ready %b busy %b r=%h c=%b v=%b want 0 1 0 0 0 0",
                     out_valid, in_ready, busy, out_result, out_carry, out_overflow);
        end
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset_quiet %0d: valid %b busy %b want 0 0", i, out_valid, busy);
            end
        end
        run_op(32'h00000001, 32'h00000002, 1'b0, 0, "post_reset_add");
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = W'($urandom);
            b = W'($urandom);
            if (n % 8 == 0) b = a;
            if (n % 8 == 1) a = 32'h80000000;
            run_op(a, b, 1'($urandom), int'($urandom_range(0, 2)), "random");
            if ($urandom_range(0, 1) == 1) step();
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 6; n++) begin
            run_op(W'($urandom), W'($urandom), n[0], 0, "back_to_back");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_idle_out_ready();
        test_mid_reset();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
